// File: rtl/mda_video_timing_if.sv
// Raster timing bus: PLL lock in, counters/syncs/cell coordinates/blink phases out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the producer drives every field every cycle.
interface mda_video_timing_if;
  logic       locked;
  logic [9:0] hcount;
  logic [8:0] vcount;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic [6:0] col;
  logic [3:0] dot;
  logic [4:0] row;
  logic [3:0] scan;
  logic       line_start;
  logic       frame_start;
  logic       blink_cur;
  logic       blink_chr;

  modport master (
    input  locked,
    output hcount, vcount, de, hsync, vsync, col, dot, row, scan,
           line_start, frame_start, blink_cur, blink_chr
  );

  modport slave (
    output locked,
    input  hcount, vcount, de, hsync, vsync, col, dot, row, scan,
           line_start, frame_start, blink_cur, blink_chr
  );
endinterface

// File: rtl/mda_video_timing.sv
// MDA raster timing generator: dot/line counters, syncs, DE, text-cell coordinates, blink phases.
// Latency: lock -> first raster cycle (0,0) after the 2-flop synchronizer; all outputs registered.
// Backpressure: none; free-running while locked, held idle at (0,0) while lock is low.
module mda_video_timing #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 18,
  parameter int H_SYNC   = 135,
  parameter int H_BP     = 9,
  parameter int V_ACTIVE = 350,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 16,
  parameter int V_BP     = 0,
  parameter int CHAR_W   = 9,
  parameter int CHAR_H   = 14,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mda_video_timing_if.master  vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0] VS_FIRST  = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] VS_LAST   = 9'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DOT_LAST  = 4'(CHAR_W - 1);
  localparam logic [3:0] SCAN_LAST = 4'(CHAR_H - 1);

  logic       r_sync1, r_sync2;
  logic [9:0] r_hcount, w_hcount_nxt;
  logic [8:0] r_vcount, w_vcount_nxt;
  logic [6:0] r_col, w_col_nxt;
  logic [3:0] r_dot, w_dot_nxt;
  logic [4:0] r_row, w_row_nxt;
  logic [3:0] r_scan, w_scan_nxt;
  logic       r_de, w_de_nxt;
  logic       r_hsync, w_hsync_nxt;
  logic       r_vsync, w_vsync_nxt;
  logic       r_line_start, w_line_start_nxt;
  logic       r_frame_start, w_frame_start_nxt;
  logic [4:0] r_frame_cnt, w_frame_cnt_nxt;
  logic       w_start, w_adv_line;

  // Two-flop synchronizer for the PLL lock, which is asynchronous to the pixel clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= vt.locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next raster state; r_sync1 is the run value the registered outputs will line up with
  always_comb begin
    w_start           = r_sync1 && !r_sync2;
    w_adv_line        = 1'b0;
    w_hcount_nxt      = '0;
    w_vcount_nxt      = '0;
    w_col_nxt         = '0;
    w_dot_nxt         = '0;
    w_row_nxt         = '0;
    w_scan_nxt        = '0;
    w_de_nxt          = 1'b0;
    w_hsync_nxt       = ~HS_POL;
    w_vsync_nxt       = ~VS_POL;
    w_line_start_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_cnt_nxt   = r_frame_cnt;

    if (r_sync1) begin
      // A fresh lock restarts the raster at (0,0) instead of continuing stale counts
      w_adv_line = w_start || (r_hcount == H_LAST);

      if (!w_start && (r_hcount != H_LAST)) begin
        w_hcount_nxt = r_hcount + 10'd1;
      end

      if (w_start) begin
        w_vcount_nxt = '0;
      end else if (r_hcount == H_LAST) begin
        w_vcount_nxt = (r_vcount == V_LAST) ? 9'd0 : r_vcount + 9'd1;
      end else begin
        w_vcount_nxt = r_vcount;
      end

      // Cell column walks with the dot counter inside the active part of the line only
      if ((w_hcount_nxt != 10'd0) && (w_hcount_nxt < H_ACT)) begin
        if (r_dot == DOT_LAST) begin
          w_dot_nxt = '0;
          w_col_nxt = r_col + 7'd1;
        end else begin
          w_dot_nxt = r_dot + 4'd1;
          w_col_nxt = r_col;
        end
      end

      // Cell row walks with the scanline counter once per line, active lines only
      if (w_adv_line) begin
        if ((w_vcount_nxt != 9'd0) && (w_vcount_nxt < V_ACT)) begin
          if (r_scan == SCAN_LAST) begin
            w_scan_nxt = '0;
            w_row_nxt  = r_row + 5'd1;
          end else begin
            w_scan_nxt = r_scan + 4'd1;
            w_row_nxt  = r_row;
          end
        end
      end else begin
        w_scan_nxt = r_scan;
        w_row_nxt  = r_row;
      end

      w_de_nxt = (w_hcount_nxt < H_ACT) && (w_vcount_nxt < V_ACT);

      if ((w_hcount_nxt >= HS_FIRST) && (w_hcount_nxt <= HS_LAST)) begin
        w_hsync_nxt = HS_POL;
      end
      // Inclusive last-line compare so a zero back porch still ends sync at the wrap
      if ((w_vcount_nxt >= VS_FIRST) && (w_vcount_nxt <= VS_LAST)) begin
        w_vsync_nxt = VS_POL;
      end

      w_line_start_nxt  = (w_hcount_nxt == 10'd0);
      w_frame_start_nxt = w_line_start_nxt && (w_vcount_nxt == 9'd0);

      if (w_frame_start_nxt) begin
        w_frame_cnt_nxt = r_frame_cnt + 5'd1;
      end
    end
  end

  // Raster state and decoded outputs; the frame counter survives lock loss, only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_col         <= '0;
      r_dot         <= '0;
      r_row         <= '0;
      r_scan        <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_col         <= w_col_nxt;
      r_dot         <= w_dot_nxt;
      r_row         <= w_row_nxt;
      r_scan        <= w_scan_nxt;
      r_de          <= w_de_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
    end
  end

  assign vt.hcount      = r_hcount;
  assign vt.vcount      = r_vcount;
  assign vt.col         = r_col;
  assign vt.dot         = r_dot;
  assign vt.row         = r_row;
  assign vt.scan        = r_scan;
  assign vt.de          = r_de;
  assign vt.hsync       = r_hsync;
  assign vt.vsync       = r_vsync;
  assign vt.line_start  = r_line_start;
  assign vt.frame_start = r_frame_start;
  assign vt.blink_cur   = r_frame_cnt[3];
  assign vt.blink_chr   = r_frame_cnt[4];

endmodule

// File: tb/tb_mda_video_timing.sv
// Bench for mda_video_timing: a reduced geometry (full blink wrap within budget) and the default MDA geometry.
// Latency: expectations pushed at each clock edge, popped and compared 1 ns later.
// Backpressure: none; the DUT presents a raster sample every cycle.
`timescale 1ns/1ps
module tb_mda_video_timing;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int cw; int ch;
    bit hpol; bit vpol;
  } geom_t;

  // Small geometry with zero back porches and inverted polarities; default MDA geometry
  localparam geom_t G0 = '{ha:18, hfp:2, hs:3, hbp:0, va:12, vfp:1, vs:2, vbp:0,
                           cw:3, ch:4, hpol:1'b0, vpol:1'b1};
  localparam geom_t G1 = '{ha:720, hfp:18, hs:135, hbp:9, va:350, vfp:4, vs:16, vbp:0,
                           cw:9, ch:14, hpol:1'b1, vpol:1'b0};
  localparam int HT0 = 23;
  localparam int FR0 = 23 * 15;

  typedef struct packed {
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [6:0] col;
    logic [3:0] dot;
    logic [4:0] row;
    logic [3:0] scan;
    logic       line_start;
    logic       frame_start;
    logic       blink_cur;
    logic       blink_chr;
  } obs_t;

  logic clk;
  logic rst;
  logic locked;

  mda_video_timing_if vif0();
  mda_video_timing_if vif1();
  assign vif0.locked = locked;
  assign vif1.locked = locked;

  mda_video_timing #(
    .H_ACTIVE(G0.ha), .H_FP(G0.hfp), .H_SYNC(G0.hs), .H_BP(G0.hbp),
    .V_ACTIVE(G0.va), .V_FP(G0.vfp), .V_SYNC(G0.vs), .V_BP(G0.vbp),
    .CHAR_W(G0.cw), .CHAR_H(G0.ch), .HS_POL(G0.hpol), .VS_POL(G0.vpol)
  ) u_dut0 (.clk(clk), .rst(rst), .vt(vif0.master));

  mda_video_timing u_dut1 (.clk(clk), .rst(rst), .vt(vif1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t q0[$];
  obs_t q1[$];

  // Reference model state per DUT: synchronizer stages, raster position within frame, frame count
  bit m_s1 [2];
  bit m_s2 [2];
  int m_p  [2];
  int m_cnt[2];

  // Expected outputs from the raster position with plain division/modulo
  function automatic obs_t model_out(geom_t g, bit run, int p, int cnt);
    obs_t o;
    int   ht, h, v;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    o = '0;
    o.hsync     = ~g.hpol;
    o.vsync     = ~g.vpol;
    o.blink_cur = ((cnt >> 3) & 1) != 0;
    o.blink_chr = ((cnt >> 4) & 1) != 0;
    if (run) begin
      h = p % ht;
      v = p / ht;
      o.hcount = 10'(h);
      o.vcount = 9'(v);
      o.de     = (h < g.ha) && (v < g.va);
      if (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs) o.hsync = g.hpol;
      if (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs) o.vsync = g.vpol;
      if (h < g.ha) begin
        o.col = 7'(h / g.cw);
        o.dot = 4'(h % g.cw);
      end
      if (v < g.va) begin
        o.row  = 5'(v / g.ch);
        o.scan = 4'(v % g.ch);
      end
      o.line_start  = (h == 0);
      o.frame_start = (p == 0);
    end
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b col=%0d dot=%0d row=%0d scan=%0d ls=%b fs=%b bc=%b bk=%b | exp h=%0d v=%0d de=%b hs=%b vs=%b col=%0d dot=%0d row=%0d scan=%0d ls=%b fs=%b bc=%b bk=%b",
               name, $time,
               got.hcount, got.vcount, got.de, got.hsync, got.vsync, got.col, got.dot, got.row, got.scan,
               got.line_start, got.frame_start, got.blink_cur, got.blink_chr,
               exp.hcount, exp.vcount, exp.de, exp.hsync, exp.vsync, exp.col, exp.dot, exp.row, exp.scan,
               exp.line_start, exp.frame_start, exp.blink_cur, exp.blink_chr);
    end
  endtask

  function automatic obs_t sample0();
    return {vif0.hcount, vif0.vcount, vif0.de, vif0.hsync, vif0.vsync, vif0.col, vif0.dot,
            vif0.row, vif0.scan, vif0.line_start, vif0.frame_start, vif0.blink_cur, vif0.blink_chr};
  endfunction

  function automatic obs_t sample1();
    return {vif1.hcount, vif1.vcount, vif1.de, vif1.hsync, vif1.vsync, vif1.col, vif1.dot,
            vif1.row, vif1.scan, vif1.line_start, vif1.frame_start, vif1.blink_cur, vif1.blink_chr};
  endfunction

  // Model: advance at every rising edge and push what each DUT must show for the coming cycle
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = 1'b0; m_s2[d] = 1'b0; m_p[d] = 0; m_cnt[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        geom_t g;
        bit    run_now;
        int    flen;
        obs_t  e;
        g    = (d == 0) ? G0 : G1;
        flen = (g.ha + g.hfp + g.hs + g.hbp) * (g.va + g.vfp + g.vs + g.vbp);
        if (!rst) begin
          m_s1[d] = 1'b0; m_s2[d] = 1'b0; m_p[d] = 0; m_cnt[d] = 0;
          e = model_out(g, 1'b0, 0, 0);
        end else begin
          run_now = m_s1[d];
          if (run_now) begin
            m_p[d] = m_s2[d] ? (m_p[d] + 1) % flen : 0;
            if (m_p[d] == 0) m_cnt[d] = (m_cnt[d] + 1) % 32;
          end
          m_s2[d] = m_s1[d];
          m_s1[d] = locked;
          e = model_out(g, run_now, m_p[d], m_cnt[d]);
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  end

  // Monitor: pop and compare one sample per DUT, away from the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check("dut0_raster", sample0(), q0.pop_front());
      if (q1.size() > 0) check("dut1_raster", sample1(), q1.pop_front());
    end
  end

  // Stimulus: reset, long free run, a directed mid-frame lock drop, random lock glitches, mid-run reset
  initial begin
    int drop_left;
    int target;
    locked = 1'b1;
    rst    = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;

    // 33 small frames: blink counter of dut0 passes 16 and wraps at 32
    repeat (33 * FR0 + 40) @(negedge clk);

    // Directed drop at (h=10, v=7) of dut0 for 50 clocks
    target = 7 * HT0 + 10;
    for (int i = 0; i < 2 * FR0; i++) begin
      if (m_s2[0] && m_p[0] == target) break;
      @(negedge clk);
    end
    locked = 1'b0;
    repeat (50) @(negedge clk);
    locked = 1'b1;
    repeat (3 * FR0) @(negedge clk);

    // Random lock drops, including single-cycle glitches
    drop_left = 0;
    for (int i = 0; i < 18000; i++) begin
      @(negedge clk);
      if (drop_left > 0) begin
        drop_left--;
        locked = (drop_left == 0);
      end else if ($urandom_range(0, 599) == 0) begin
        drop_left = $urandom_range(1, 40);
        locked    = 1'b0;
      end
    end
    locked = 1'b1;
    repeat (FR0 + 7) @(negedge clk);

    // Asynchronous reset mid-run: outputs clear without waiting for a clock edge
    rst = 1'b0;
    #1;
    check("async_reset_dut0", sample0(), model_out(G0, 1'b0, 0, 0));
    check("async_reset_dut1", sample1(), model_out(G1, 1'b0, 0, 0));
    repeat (3) @(negedge clk);

    // Release reset with lock low, then lock later
    locked = 1'b0;
    rst    = 1'b1;
    repeat (10) @(negedge clk);
    locked = 1'b1;
    repeat (2 * FR0) @(negedge clk);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
